// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction-timer game core: FSM states,
// the millisecond saturation limit and the LFSR feedback taps.
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    GO,
    DONE,
    FOUL
  } rtState_t;

  localparam int          MS_W   = 13;
  localparam logic [12:0] MAX_MS = 13'd8191;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsrStep(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for an asynchronous button followed by a registered
// rising-edge detector producing a single-cycle press pulse.
module button_sync_edge (
  input  logic clk,
  input  logic resetN,
  input  logic rawIn,
  output logic pulse
);

  logic syncMeta;
  logic syncStable;
  logic syncLast;

  // NOTE: non-blocking assignments make every flop sample its pre-edge input;
  // blocking ones would collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      syncMeta   <= 1'b0;
      syncStable <= 1'b0;
      syncLast   <= 1'b0;
      pulse      <= 1'b0;
    end else begin
      syncMeta   <= rawIn;
      syncStable <= syncMeta;
      syncLast   <= syncStable;
      pulse      <= syncStable & ~syncLast;
    end
  end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-timer timing core: random wait, go LED, millisecond measurement,
// false-start and timeout flags. Define RT_BEST_TIME_EN to build the best-time tracker.
module reaction_timer_core
  import reaction_timer_pkg::*;
#(
  parameter int          CLK_HZ       = 100000000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            startButton,
  input  logic            reactButton,
  output logic            goLed,
  output logic [MS_W-1:0] timeToDisplay,
  output logic            resultValid,
  output logic            falseStart,
  output logic            timeout,
  output logic [MS_W-1:0] bestTime
);

  localparam int                TICK_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int                PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

  rtState_t        state;
  rtState_t        nextState;
  logic            startPulse;
  logic            reactPulse;
  logic [15:0]     lfsr;
  logic [PRE_W-1:0] prescale;
  logic            msTick;
  logic [MS_W-1:0] delayCount;
  logic            enterWait;
  logic            enterGo;
  logic            satHit;
  logic            goLedNext;
  logic            resultValidNext;
  logic            falseStartNext;
  logic            timeoutNext;

  button_sync_edge startSync (
    .clk    (clk),
    .resetN (resetN),
    .rawIn  (startButton),
    .pulse  (startPulse)
  );

  button_sync_edge reactSync (
    .clk    (clk),
    .resetN (resetN),
    .rawIn  (reactButton),
    .pulse  (reactPulse)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr <= LFSR_SEED;
    else         lfsr <= lfsrStep(lfsr);
  end

  assign msTick    = (prescale == PRE_LAST);
  assign enterWait = (nextState == WAIT) && (state != WAIT);
  assign enterGo   = (nextState == GO) && (state != GO);
  // The tick that would carry the count to its ceiling ends the round as a timeout.
  assign satHit    = (state == GO) && !reactPulse && msTick &&
                     (timeToDisplay == MAX_MS - 13'd1);

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      goLed       <= 1'b0;
      resultValid <= 1'b0;
      falseStart  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= nextState;
      goLed       <= goLedNext;
      resultValid <= resultValidNext;
      falseStart  <= falseStartNext;
      timeout     <= timeoutNext;
    end
  end

  // NOTE: nextState gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (startPulse) nextState = WAIT;
      WAIT: begin
        if (reactPulse)                             nextState = FOUL;
        else if (msTick && delayCount <= 13'd1)     nextState = GO;
      end
      GO: begin
        if (reactPulse || satHit) nextState = DONE;
      end
      DONE: if (startPulse) nextState = WAIT;
      FOUL: if (startPulse) nextState = WAIT;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    goLedNext       = (nextState == GO);
    resultValidNext = (nextState == DONE);
    falseStartNext  = (nextState == FOUL);
    timeoutNext     = (nextState == DONE) && ((state == DONE) ? timeout : satHit);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prescale      <= '0;
      delayCount    <= '0;
      timeToDisplay <= '0;
    end else begin
      if (enterWait || enterGo || msTick) prescale <= '0;
      else                                prescale <= prescale + PRE_W'(1);

      if (enterWait)
        delayCount <= 13'(MIN_DELAY_MS) + {2'b00, lfsr[10:0]};
      else if (state == WAIT && msTick && delayCount != '0)
        delayCount <= delayCount - 13'd1;

      // The displayed value is the live counter; it freezes once GO is left.
      if (enterWait || enterGo)
        timeToDisplay <= '0;
      else if (state == GO && !reactPulse && msTick && timeToDisplay != MAX_MS)
        timeToDisplay <= timeToDisplay + 13'd1;
    end
  end

`ifdef RT_BEST_TIME_EN
  logic bestValid;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bestValid <= 1'b0;
      bestTime  <= '0;
    end else if (state == GO && reactPulse &&
                 (!bestValid || timeToDisplay < bestTime)) begin
      bestValid <= 1'b1;
      bestTime  <= timeToDisplay;
    end
  end
`else
  assign bestTime = '0;
`endif

endmodule
